// File: rtl/calc1_pkg.sv
// Shared calc1 encodings: command and response codes plus the port checker state type.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_IERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_WAIT
    } chk_state_t;

endpackage

// File: rtl/calc1_expect.sv
// Combinational reference model of a calc1 response for one command and its two operands.
module calc1_expect
    import calc1_pkg::*;
(
    input  logic [3:0]  cmd,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [1:0]  exp_resp,
    output logic [31:0] exp_data
);

    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        sum      = {1'b0, op1} + {1'b0, op2};
        // Bit 32 of the difference is the borrow, set exactly when op2 > op1.
        diff     = {1'b0, op1} - {1'b0, op2};
        exp_resp = RESP_ERR;
        exp_data = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[32]) begin
                    exp_resp = RESP_OK;
                    exp_data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (!diff[32]) begin
                    exp_resp = RESP_OK;
                    exp_data = diff[31:0];
                end
            end
            CMD_LSH: begin
                exp_resp = RESP_OK;
                exp_data = op1 << op2[4:0];
            end
            CMD_RSH: begin
                exp_resp = RESP_OK;
                exp_data = op1 >> op2[4:0];
            end
            default: begin
                exp_resp = RESP_ERR;
                exp_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_checker.sv
// Per-port calc1 response checker: snoops a two-cycle request, predicts the response,
// then scores the DUT reply as pass, fail, timeout or protocol error with saturating tallies.
module calc1_port_checker
    import calc1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic [0:3]       req_cmd,
    input  logic [0:31]      req_data,
    input  logic [0:1]       out_resp,
    input  logic [0:31]      out_data,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic             chk_fail,
    output logic             chk_timeout,
    output logic             proto_err,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned   TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    // calc1 ports number bit 0 as MSB; repack so arithmetic sees ordinary vectors.
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  resp_in;
    logic [31:0] rdata_in;

    assign cmd_in   = req_cmd;
    assign data_in  = req_data;
    assign resp_in  = out_resp;
    assign rdata_in = out_data;

    chk_state_t  state, state_nxt;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [TW-1:0] timer;

    logic [1:0]  exp_resp;
    logic [31:0] exp_data;

    logic latch_cmd, latch_op2, done, pass_now, timeout_now, perr_nxt;

    calc1_expect u_expect (
        .cmd      (cmd_q),
        .op1      (op1_q),
        .op2      (op2_q),
        .exp_resp (exp_resp),
        .exp_data (exp_data)
    );

    always_comb begin
        state_nxt   = state;
        latch_cmd   = 1'b0;
        latch_op2   = 1'b0;
        done        = 1'b0;
        pass_now    = 1'b0;
        timeout_now = 1'b0;
        perr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_in != CMD_NOP) begin
                    latch_cmd = 1'b1;
                    state_nxt = ST_OP2;
                end
                if (resp_in != RESP_NONE) perr_nxt = 1'b1;
            end
            ST_OP2: begin
                latch_op2 = 1'b1;
                state_nxt = ST_WAIT;
                if (cmd_in != CMD_NOP || resp_in != RESP_NONE) perr_nxt = 1'b1;
            end
            ST_WAIT: begin
                if (resp_in != RESP_NONE) begin
                    done     = 1'b1;
                    pass_now = (resp_in == exp_resp) &&
                               (exp_resp != RESP_OK || rdata_in == exp_data);
                    if (cmd_in != CMD_NOP) begin
                        latch_cmd = 1'b1;
                        state_nxt = ST_OP2;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    if (cmd_in != CMD_NOP) perr_nxt = 1'b1;
                    if (timer == T_LAST) begin
                        timeout_now = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            timer       <= '0;
            chk_valid   <= 1'b0;
            chk_pass    <= 1'b0;
            chk_fail    <= 1'b0;
            chk_timeout <= 1'b0;
            proto_err   <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            chk_valid   <= done;
            chk_pass    <= done && pass_now;
            chk_fail    <= done && !pass_now;
            chk_timeout <= timeout_now;
            proto_err   <= perr_nxt;
            if (latch_cmd) begin
                cmd_q <= cmd_in;
                op1_q <= data_in;
            end
            if (latch_op2) begin
                op2_q <= data_in;
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + 1'b1;
            end
            if (done && pass_now && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (((done && !pass_now) || timeout_now) && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_calc1_port_checker.sv
// Directed bench for calc1_port_checker: vector table plus hand-built multi-cycle sequences.
module tb_calc1_port_checker;
    import calc1_pkg::*;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [0:3]  req_cmd;
    logic [0:31] req_data;
    logic [0:1]  out_resp;
    logic [0:31] out_data;

    logic        chk_valid, chk_pass, chk_fail, chk_timeout, proto_err, busy;
    logic [15:0] pass_cnt, fail_cnt;
    logic        s_valid, s_pass, s_fail, s_timeout, s_perr, s_busy;
    logic [1:0]  s_pass_cnt, s_fail_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pass_m = 0, fail_m = 0, s_pass_m = 0, s_fail_m = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int unsigned dly;
        logic [1:0]  resp;
        logic [31:0] data;
        bit          pass;
    } vec_t;

    vec_t vecs[14];

    calc1_port_checker #(.TIMEOUT(64), .CNT_W(16)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd(req_cmd), .req_data(req_data),
        .out_resp(out_resp), .out_data(out_data), .chk_valid(chk_valid),
        .chk_pass(chk_pass), .chk_fail(chk_fail), .chk_timeout(chk_timeout),
        .proto_err(proto_err), .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    calc1_port_checker #(.TIMEOUT(64), .CNT_W(2)) dut_sat (
        .c_clk(c_clk), .reset(reset), .req_cmd(req_cmd), .req_data(req_data),
        .out_resp(out_resp), .out_data(out_data), .chk_valid(s_valid),
        .chk_pass(s_pass), .chk_fail(s_fail), .chk_timeout(s_timeout),
        .proto_err(s_perr), .busy(s_busy), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note(input bit p);
        if (p) begin
            if (pass_m < 32'hFFFF) pass_m++;
            if (s_pass_m < 3) s_pass_m++;
        end else begin
            if (fail_m < 32'hFFFF) fail_m++;
            if (s_fail_m < 3) s_fail_m++;
        end
    endtask

    task automatic check_counts(input string name);
        check({name, " pass_cnt"}, pass_cnt, pass_m);
        check({name, " fail_cnt"}, fail_cnt, fail_m);
        check({name, " sat pass_cnt"}, s_pass_cnt, s_pass_m);
        check({name, " sat fail_cnt"}, s_fail_cnt, s_fail_m);
    endtask

    task automatic check_zero(input string name);
        check({name, " chk_valid"}, chk_valid, 0);
        check({name, " chk_pass"}, chk_pass, 0);
        check({name, " chk_fail"}, chk_fail, 0);
        check({name, " chk_timeout"}, chk_timeout, 0);
        check({name, " proto_err"}, proto_err, 0);
        check({name, " busy"}, busy, 0);
        check({name, " pass_cnt"}, pass_cnt, 0);
        check({name, " fail_cnt"}, fail_cnt, 0);
    endtask

    task automatic check_result(input string name, input bit p);
        check({name, " chk_valid"}, chk_valid, 1);
        check({name, " chk_pass"}, chk_pass, p);
        check({name, " chk_fail"}, chk_fail, !p);
        check({name, " chk_timeout"}, chk_timeout, 0);
        check_counts(name);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        req_cmd = v.cmd; req_data = v.op1;
        step();
        check({name, " busy cmd"}, busy, 1);
        req_cmd = '0; req_data = v.op2;
        step();
        req_data = '0;
        repeat (v.dly) step();
        out_resp = v.resp; out_data = v.data;
        step();
        out_resp = '0; out_data = '0;
        note(v.pass);
        check_result(name, v.pass);
        check({name, " proto_err"}, proto_err, 0);
        check({name, " busy end"}, busy, 0);
    endtask

    initial begin
        vecs[0]  = '{CMD_ADD, 32'hFFFF0000, 32'h0000FFFF, 0, 2'd1, 32'hFFFFFFFF, 1'b1};
        vecs[1]  = '{CMD_ADD, 32'hFFFFFFFF, 32'h00000001, 1, 2'd1, 32'h00000000, 1'b0};
        vecs[2]  = '{CMD_ADD, 32'hFFFFFFFF, 32'h00000001, 2, 2'd2, 32'h00000000, 1'b1};
        vecs[3]  = '{CMD_SUB, 32'h00000001, 32'h00000002, 0, 2'd2, 32'h00000000, 1'b1};
        vecs[4]  = '{CMD_LSH, 32'h00000001, 32'h00000021, 3, 2'd1, 32'h00000002, 1'b1};
        vecs[5]  = '{CMD_RSH, 32'h80000000, 32'h0000001F, 1, 2'd1, 32'h00000001, 1'b1};
        vecs[6]  = '{CMD_SUB, 32'h0000000A, 32'h00000003, 4, 2'd1, 32'h00000007, 1'b1};
        vecs[7]  = '{CMD_SUB, 32'h00000005, 32'h00000005, 0, 2'd1, 32'h00000000, 1'b1};
        vecs[8]  = '{CMD_ADD, 32'h00000001, 32'h00000002, 2, 2'd3, 32'h00000003, 1'b0};
        vecs[9]  = '{4'd7,    32'h12345678, 32'h00000001, 1, 2'd2, 32'h00000000, 1'b1};
        vecs[10] = '{CMD_ADD, 32'h7FFFFFFF, 32'h80000000, 0, 2'd1, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{CMD_LSH, 32'h000000F0, 32'h00000004, 5, 2'd1, 32'h00000F01, 1'b0};
        vecs[12] = '{CMD_SUB, 32'h00000003, 32'h00000001, 1, 2'd2, 32'h00000000, 1'b0};
        vecs[13] = '{4'd3,    32'h00000004, 32'h00000004, 0, 2'd1, 32'h00000008, 1'b0};

        reset = 1'b0; req_cmd = '0; req_data = '0; out_resp = '0; out_data = '0;
        repeat (2) step();
        check_zero("reset");
        reset = 1'b1;
        step();

        for (int unsigned i = 0; i < 14; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d valid drop", i), chk_valid, 0);
        end

        // Unsolicited response while idle.
        out_resp = 2'd1; out_data = 32'h1;
        step();
        out_resp = '0; out_data = '0;
        check("idle resp proto_err", proto_err, 1);
        check("idle resp chk_valid", chk_valid, 0);
        step();
        check("idle resp pulse end", proto_err, 0);

        // Timeout: pulse 64 edges after op2 capture.
        req_cmd = CMD_ADD; req_data = 32'h5;
        step();
        req_cmd = '0; req_data = 32'h6;
        step();
        req_data = '0;
        repeat (63) step();
        check("timeout early", chk_timeout, 0);
        check("timeout busy early", busy, 1);
        step();
        note(1'b0);
        check("timeout pulse", chk_timeout, 1);
        check("timeout chk_valid", chk_valid, 0);
        check("timeout busy", busy, 0);
        check_counts("timeout");
        step();
        check("timeout pulse end", chk_timeout, 0);

        // Response arriving on the final timer cycle beats the timeout.
        req_cmd = CMD_ADD; req_data = 32'h5;
        step();
        req_cmd = '0; req_data = 32'h6;
        step();
        req_data = '0;
        repeat (63) step();
        out_resp = 2'd1; out_data = 32'hB;
        step();
        out_resp = '0; out_data = '0;
        note(1'b1);
        check_result("last-cycle resp", 1'b1);

        // Command during op2 cycle: proto_err, op2 still taken.
        req_cmd = CMD_ADD; req_data = 32'd10;
        step();
        req_cmd = CMD_ADD; req_data = 32'd20;
        step();
        req_cmd = '0; req_data = '0;
        check("op2 cmd proto_err", proto_err, 1);
        check("op2 cmd busy", busy, 1);
        out_resp = 2'd1; out_data = 32'd30;
        step();
        out_resp = '0; out_data = '0;
        note(1'b1);
        check_result("op2 cmd", 1'b1);

        // Second ADD issued while waiting: ignored, flagged.
        req_cmd = CMD_ADD; req_data = 32'd100;
        step();
        req_cmd = '0; req_data = 32'd23;
        step();
        req_cmd = CMD_ADD; req_data = 32'hDEAD;
        step();
        req_cmd = '0; req_data = '0;
        check("wait cmd proto_err", proto_err, 1);
        check("wait cmd busy", busy, 1);
        step();
        check("wait cmd pulse end", proto_err, 0);
        out_resp = 2'd1; out_data = 32'd123;
        step();
        out_resp = '0; out_data = '0;
        note(1'b1);
        check_result("wait cmd", 1'b1);

        // Back-to-back: new command accepted alongside the response.
        req_cmd = CMD_SUB; req_data = 32'd50;
        step();
        req_cmd = '0; req_data = 32'd8;
        step();
        req_data = '0;
        out_resp = 2'd1; out_data = 32'd42;
        req_cmd = CMD_RSH; req_data = 32'h00000100;
        step();
        out_resp = '0; out_data = '0;
        note(1'b1);
        check_result("b2b first", 1'b1);
        check("b2b proto_err", proto_err, 0);
        check("b2b busy", busy, 1);
        req_cmd = '0; req_data = 32'd4;
        step();
        req_data = '0;
        out_resp = 2'd1; out_data = 32'h10;
        step();
        out_resp = '0; out_data = '0;
        note(1'b1);
        check_result("b2b second", 1'b1);
        check("b2b second proto_err", proto_err, 0);

        // Reset mid-WAIT aborts silently and clears tallies.
        req_cmd = CMD_ADD; req_data = 32'd1;
        step();
        req_cmd = '0; req_data = 32'd1;
        step();
        req_data = '0;
        step();
        reset = 1'b0;
        #1;
        check_zero("mid reset");
        out_resp = 2'd1; out_data = 32'd2;
        step();
        out_resp = '0; out_data = '0;
        check_zero("mid reset held");
        reset = 1'b1;
        pass_m = 0; fail_m = 0; s_pass_m = 0; s_fail_m = 0;
        step();
        check("after reset chk_valid", chk_valid, 0);
        run_txn('{CMD_ADD, 32'd2, 32'd3, 0, 2'd1, 32'd5, 1'b1}, "post reset");

        // Five more passes: the 2-bit tally pins at 3.
        for (int unsigned i = 0; i < 5; i++) begin
            run_txn('{CMD_ADD, 32'd10 * i, 32'd7, i, 2'd1, 32'd10 * i + 32'd7, 1'b1},
                    $sformatf("sat%0d", i));
        end
        check("sat final", s_pass_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
